// File: rtl/spu_pipe_stage.sv
// Multi-lane SPU pipeline register with valid/ready handshake, flush, per-lane kill and stall counter.
// Define SPU_PIPE_SKID_EN for a 2-entry skid buffer with registered in_ready; default is a single register.
module spu_pipe_stage #(
  parameter int LANES     = 2,
  parameter int PAYLOAD_W = 465,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES-1:0]           in_lane_valid,
  input  logic [LANES*PAYLOAD_W-1:0] in_payload,
  input  logic [LANES-1:0]           kill_mask,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES-1:0]           out_lane_valid,
  output logic [LANES*PAYLOAD_W-1:0] out_payload,
  output logic [1:0]                 occupancy,
  output logic [CNT_W-1:0]           stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic [LANES-1:0]             main_lv_p1, main_lv_d;
  logic [LANES*PAYLOAD_W-1:0]   main_pl_p1, main_pl_d;
  logic [LANES-1:0]             cap_lv;
  logic                         in_fire;
  logic                         out_fire;
  logic                         cap_store;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

`ifdef SPU_PIPE_SKID_EN
  logic [LANES-1:0]             skid_lv_p1, skid_lv_d;
  logic [LANES*PAYLOAD_W-1:0]   skid_pl_p1, skid_pl_d;
  logic                         in_ready_q;

  assign in_ready = in_ready_q;
`else
  assign in_ready = ~out_valid | out_ready;
`endif

  assign out_valid      = (state_q != EMPTY);
  assign occupancy      = state_q;
  assign out_lane_valid = main_lv_p1;
  assign out_payload    = main_pl_p1;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign cap_lv    = in_lane_valid & ~kill_mask;
  // A bundle whose lanes are all squashed is consumed but never stored.
  assign cap_store = in_fire & (|cap_lv);

  always_comb begin
    state_d   = state_q;
    main_lv_d = main_lv_p1;
    main_pl_d = main_pl_p1;
`ifdef SPU_PIPE_SKID_EN
    skid_lv_d = skid_lv_p1;
    skid_pl_d = skid_pl_p1;
`endif
    if (flush) begin
      state_d   = EMPTY;
      main_lv_d = '0;
`ifdef SPU_PIPE_SKID_EN
      skid_lv_d = '0;
`endif
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (cap_store) begin
            state_d   = ONE;
            main_lv_d = cap_lv;
            main_pl_d = in_payload;
          end
        end
        ONE: begin
          if (cap_store && out_fire) begin
            main_lv_d = cap_lv;
            main_pl_d = in_payload;
          end else if (out_fire) begin
            state_d = EMPTY;
`ifdef SPU_PIPE_SKID_EN
          end else if (cap_store) begin
            state_d   = TWO;
            skid_lv_d = cap_lv;
            skid_pl_d = in_payload;
`endif
          end
        end
        TWO: begin
`ifdef SPU_PIPE_SKID_EN
          if (out_fire) begin
            state_d   = ONE;
            main_lv_d = skid_lv_p1;
            main_pl_d = skid_pl_p1;
          end
`endif
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Stage register boundary: head/skid storage, state and stall counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      main_lv_p1 <= '0;
      main_pl_p1 <= '0;
      stall_cnt  <= '0;
`ifdef SPU_PIPE_SKID_EN
      skid_lv_p1 <= '0;
      skid_pl_p1 <= '0;
      in_ready_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      main_lv_p1 <= main_lv_d;
      main_pl_p1 <= main_pl_d;
      if (out_valid && !out_ready) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
`ifdef SPU_PIPE_SKID_EN
      skid_lv_p1 <= skid_lv_d;
      skid_pl_p1 <= skid_pl_d;
      in_ready_q <= (state_d != TWO);
`endif
    end
  end

endmodule

// File: tb/tb_spu_pipe_stage.sv
// Self-checking bench for spu_pipe_stage: queue-based reference model, directed and random stimulus.
// Follows SPU_PIPE_SKID_EN to pick the expected buffer depth.
module tb_spu_pipe_stage;
  localparam int LANES = 2;
  localparam int PW    = 40;
`ifdef SPU_PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [LANES-1:0]    lv;
    logic [LANES*PW-1:0] pl;
  } bundle_t;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  in_valid = 1'b0;
  logic [LANES-1:0]      in_lane_valid = '0;
  logic [LANES*PW-1:0]   in_payload = '0;
  logic [LANES-1:0]      kill_mask = '0;
  logic                  flush = 1'b0;
  logic                  out_ready = 1'b0;
  logic                  in_ready, out_valid;
  logic [LANES-1:0]      out_lane_valid;
  logic [LANES*PW-1:0]   out_payload;
  logic [1:0]            occupancy;
  logic [15:0]           stall_cnt;
  logic                  in_ready_c2, out_valid_c2;
  logic [LANES-1:0]      out_lane_valid_c2;
  logic [LANES*PW-1:0]   out_payload_c2;
  logic [1:0]            occupancy_c2;
  logic [1:0]            stall_cnt_c2;

  spu_pipe_stage #(.LANES(LANES), .PAYLOAD_W(PW), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_valid(in_lane_valid), .in_payload(in_payload), .kill_mask(kill_mask),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_lane_valid(out_lane_valid), .out_payload(out_payload),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  spu_pipe_stage #(.LANES(LANES), .PAYLOAD_W(PW), .CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_c2),
    .in_lane_valid(in_lane_valid), .in_payload(in_payload), .kill_mask(kill_mask),
    .flush(flush), .out_valid(out_valid_c2), .out_ready(out_ready),
    .out_lane_valid(out_lane_valid_c2), .out_payload(out_payload_c2),
    .occupancy(occupancy_c2), .stall_cnt(stall_cnt_c2)
  );

  always #5 clk = ~clk;

  // Reference model: a FIFO of stored bundles plus what the outputs currently show.
  bundle_t     q[$];
  bundle_t     last;
  logic [15:0] stall16;
  logic [1:0]  stall2;
  logic        m_ready;
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic logic exp_ready();
    return SKID ? m_ready : (q.size() == 0 || out_ready);
  endfunction

  function automatic logic [5:0] exp_ctrl();
    return {q.size() != 0, exp_ready(), 2'(q.size()), last.lv};
  endfunction

  task automatic model_reset();
    q.delete();
    last    = '0;
    stall16 = '0;
    stall2  = '0;
    m_ready = 1'b1;
  endtask

  task automatic model_edge();
    logic    rdy, ov;
    bundle_t b;
    rdy = exp_ready();
    ov  = (q.size() != 0);
    if (ov && !out_ready) begin
      if (stall16 != 16'hFFFF) stall16 = stall16 + 16'd1;
      if (stall2 != 2'd3) stall2 = stall2 + 2'd1;
    end
    if (flush) begin
      q.delete();
      last.lv = '0;
    end else begin
      if (ov && out_ready) void'(q.pop_front());
      if (in_valid && rdy && |(in_lane_valid & ~kill_mask)) begin
        b.lv = in_lane_valid & ~kill_mask;
        b.pl = in_payload;
        q.push_back(b);
      end
      if (q.size() != 0) last = q[0];
    end
    m_ready = (q.size() < 2);
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] lv, input logic [1:0] km,
                       input logic [LANES*PW-1:0] pl, input logic ordy, input logic fl);
    in_valid      = v;
    in_lane_valid = lv;
    kill_mask     = km;
    in_payload    = pl;
    out_ready     = ordy;
    flush         = fl;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready, occupancy, out_lane_valid} !== 6'b010000) begin
      $display("FAIL reset_ctrl: got v/rdy/occ/lv %b, want 010000", {out_valid, in_ready, occupancy, out_lane_valid});
    end else n_pass++;
    n_checks++;
    if (out_payload !== '0 || stall_cnt !== '0 || stall_cnt_c2 !== '0) begin
      $display("FAIL reset_data: got payload %h stall %0d/%0d, want 0", out_payload, stall_cnt, stall_cnt_c2);
    end else n_pass++;
    reset = 1'b1;
    advance();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1'b1, 2'b11, 2'b00, {PW'(32'hA0 + i), PW'(32'h11 + i)}, 1'b1, 1'b0);
      else       drive(1'b0, 2'b00, 2'b00, '0, 1'b1, 1'b0);
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready, occupancy, out_lane_valid} !== exp_ctrl() ||
          {out_valid_c2, in_ready_c2, occupancy_c2, out_lane_valid_c2} !== exp_ctrl()) begin
        $display("FAIL stream_ctrl cyc %0d: got %b c2 %b, want %b", i,
                 {out_valid, in_ready, occupancy, out_lane_valid},
                 {out_valid_c2, in_ready_c2, occupancy_c2, out_lane_valid_c2}, exp_ctrl());
      end else n_pass++;
      n_checks++;
      if (out_payload !== last.pl || out_payload_c2 !== last.pl) begin
        $display("FAIL stream_payload cyc %0d: got %h, want %h", i, out_payload, last.pl);
      end else n_pass++;
      if (i >= 1 && i <= 4) begin
        n_checks++;
        if (out_payload[PW-1:0] !== PW'(32'h11 + i - 1)) begin
          $display("FAIL stream_order cyc %0d: got lane0 %h, want %h", i, out_payload[PW-1:0], 32'h11 + i - 1);
        end else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    for (int i = 0; i < 10; i++) begin
      drive(idx < 3, 2'b11, 2'b00, {PW'(32'hB0 + idx), PW'(32'h0A + idx)}, i >= 3, 1'b0);
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready, occupancy, out_lane_valid} !== exp_ctrl() ||
          {out_valid_c2, in_ready_c2, occupancy_c2, out_lane_valid_c2} !== exp_ctrl()) begin
        $display("FAIL bp_ctrl cyc %0d: got %b c2 %b, want %b", i,
                 {out_valid, in_ready, occupancy, out_lane_valid},
                 {out_valid_c2, in_ready_c2, occupancy_c2, out_lane_valid_c2}, exp_ctrl());
      end else n_pass++;
      n_checks++;
      if (out_payload !== last.pl || out_payload_c2 !== last.pl) begin
        $display("FAIL bp_payload cyc %0d: got %h, want %h", i, out_payload, last.pl);
      end else n_pass++;
      n_checks++;
      if (stall_cnt !== stall16 || stall_cnt_c2 !== stall2) begin
        $display("FAIL bp_stall cyc %0d: got %0d/%0d, want %0d/%0d", i, stall_cnt, stall_cnt_c2, stall16, stall2);
      end else n_pass++;
      if (in_valid && exp_ready()) idx++;
      advance();
    end
  endtask

  task automatic test_kill();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       drive(1'b1, 2'b11, 2'b10, {PW'(32'h77), PW'(32'h66)}, 1'b1, 1'b0);
        2:       drive(1'b1, 2'b11, 2'b11, {PW'(32'h99), PW'(32'h88)}, 1'b1, 1'b0);
        default: drive(1'b0, 2'b00, 2'b00, '0, 1'b1, 1'b0);
      endcase
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready, occupancy, out_lane_valid} !== exp_ctrl()) begin
        $display("FAIL kill_ctrl cyc %0d: got %b, want %b", i, {out_valid, in_ready, occupancy, out_lane_valid}, exp_ctrl());
      end else n_pass++;
      if (i == 1) begin
        n_checks++;
        if (out_lane_valid !== 2'b01 || !out_valid) begin
          $display("FAIL kill_lanes: got lv %b valid %b, want 01 valid 1", out_lane_valid, out_valid);
        end else n_pass++;
      end
      if (i == 3) begin
        n_checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
          $display("FAIL kill_all: got occ %0d valid %b, want 0 0", occupancy, out_valid);
        end else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_flush();
    logic [15:0] stall_before;
    stall_before = '0;
    for (int i = 0; i < 5; i++) begin
      if (i < 2)       drive(1'b1, 2'b11, 2'b00, {PW'(32'hC0 + i), PW'(32'hD0 + i)}, 1'b0, 1'b0);
      else if (i == 2) drive(1'b1, 2'b11, 2'b00, {PW'(32'hEE), PW'(32'hEF)}, 1'b1, 1'b1);
      else             drive(1'b0, 2'b00, 2'b00, '0, 1'b1, 1'b0);
      @(negedge clk);
      if (i == 2) stall_before = stall_cnt;
      n_checks++;
      if ({out_valid, in_ready, occupancy, out_lane_valid} !== exp_ctrl() ||
          {out_valid_c2, in_ready_c2, occupancy_c2, out_lane_valid_c2} !== exp_ctrl()) begin
        $display("FAIL flush_ctrl cyc %0d: got %b c2 %b, want %b", i,
                 {out_valid, in_ready, occupancy, out_lane_valid},
                 {out_valid_c2, in_ready_c2, occupancy_c2, out_lane_valid_c2}, exp_ctrl());
      end else n_pass++;
      n_checks++;
      if (out_payload !== last.pl || stall_cnt !== stall16) begin
        $display("FAIL flush_data cyc %0d: got pl %h stall %0d, want %h %0d", i, out_payload, stall_cnt, last.pl, stall16);
      end else n_pass++;
      if (i == 3) begin
        n_checks++;
        if ({out_valid, occupancy, in_ready} !== 4'b0001 || stall_cnt !== stall_before) begin
          $display("FAIL flush_after: got v/occ/rdy %b stall %0d, want 0001 stall %0d",
                   {out_valid, occupancy, in_ready}, stall_cnt, stall_before);
        end else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_stall_sat();
    for (int i = 0; i < 9; i++) begin
      drive(i == 0, 2'b01, 2'b00, {PW'(32'h5A), PW'(32'h5B)}, i == 8, 1'b0);
      @(negedge clk);
      n_checks++;
      if (stall_cnt !== stall16 || stall_cnt_c2 !== stall2) begin
        $display("FAIL sat_stall cyc %0d: got %0d/%0d, want %0d/%0d", i, stall_cnt, stall_cnt_c2, stall16, stall2);
      end else n_pass++;
      advance();
    end
    n_checks++;
    if (stall_cnt_c2 !== 2'd3) begin
      $display("FAIL sat_final: got %0d, want 3", stall_cnt_c2);
    end else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
            {16'($urandom), $urandom, $urandom}, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready, occupancy, out_lane_valid} !== exp_ctrl() ||
          {out_valid_c2, in_ready_c2, occupancy_c2, out_lane_valid_c2} !== exp_ctrl()) begin
        $display("FAIL rand_ctrl cyc %0d: got %b c2 %b, want %b", i,
                 {out_valid, in_ready, occupancy, out_lane_valid},
                 {out_valid_c2, in_ready_c2, occupancy_c2, out_lane_valid_c2}, exp_ctrl());
      end else n_pass++;
      n_checks++;
      if (out_payload !== last.pl || out_payload_c2 !== last.pl) begin
        $display("FAIL rand_payload cyc %0d: got %h, want %h", i, out_payload, last.pl);
      end else n_pass++;
      n_checks++;
      if (stall_cnt !== stall16 || stall_cnt_c2 !== stall2) begin
        $display("FAIL rand_stall cyc %0d: got %0d/%0d, want %0d/%0d", i, stall_cnt, stall_cnt_c2, stall16, stall2);
      end else n_pass++;
      advance();
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b11, 2'b00, {PW'(32'hF0 + i), PW'(32'hE0 + i)}, 1'b0, 1'b0);
      advance();
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({out_valid, in_ready, occupancy, out_lane_valid} !== 6'b010000 ||
        out_payload !== '0 || stall_cnt !== '0 || stall_cnt_c2 !== '0) begin
      $display("FAIL areset_now: got v/rdy/occ/lv %b pl %h stall %0d, want 010000 0 0",
               {out_valid, in_ready, occupancy, out_lane_valid}, out_payload, stall_cnt);
    end else n_pass++;
    @(posedge clk);
    #3;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(i == 0, 2'b10, 2'b00, {PW'(32'h3C), PW'(32'h3D)}, 1'b0, 1'b0);
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready, occupancy, out_lane_valid} !== exp_ctrl() || out_payload !== last.pl) begin
        $display("FAIL areset_release cyc %0d: got %b pl %h, want %b pl %h", i,
                 {out_valid, in_ready, occupancy, out_lane_valid}, out_payload, exp_ctrl(), last.pl);
      end else n_pass++;
      advance();
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_lane_valid !== 2'b10) begin
      $display("FAIL areset_capture: got valid %b lv %b, want 1 10", out_valid, out_lane_valid);
    end else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_kill();
    test_flush();
    test_stall_sat();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
